// File: rtl/commit_unit_multi_if.sv
// Commit-stage bus between the ROB head / architectural state and the
// commit unit.
//   Head lanes (to commit unit): head_valid, head_opcode, head_dest,
//     head_value, head_predict, head_tag, rf_tag, dmem_resp.
//   Retirement effects (from commit unit): rf_we, rf_clr_busy, rob_pop,
//     flush, pcmux_sel, new_pc, dmem_write, ldstr_pop, cc_out,
//     retired_cnt, mispredict_cnt.
// The master modport is the ROB/environment side; slave is the commit unit.
interface commit_unit_multi_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int ROB_ADDR_WIDTH = 3,
   parameter int COMMIT_WIDTH   = 2,
   parameter int CNT_WIDTH      = 16
);
   localparam int POP_WIDTH = $clog2(COMMIT_WIDTH + 1);

   logic [COMMIT_WIDTH-1:0]                head_valid;
   logic [4*COMMIT_WIDTH-1:0]              head_opcode;
   logic [3*COMMIT_WIDTH-1:0]              head_dest;
   logic [DATA_WIDTH*COMMIT_WIDTH-1:0]     head_value;
   logic [COMMIT_WIDTH-1:0]                head_predict;
   logic [ROB_ADDR_WIDTH*COMMIT_WIDTH-1:0] head_tag;
   logic [ROB_ADDR_WIDTH*COMMIT_WIDTH-1:0] rf_tag;
   logic                                   dmem_resp;

   logic [COMMIT_WIDTH-1:0]                rf_we;
   logic [COMMIT_WIDTH-1:0]                rf_clr_busy;
   logic [POP_WIDTH-1:0]                   rob_pop;
   logic                                   flush;
   logic                                   pcmux_sel;
   logic [DATA_WIDTH-1:0]                  new_pc;
   logic                                   dmem_write;
   logic                                   ldstr_pop;
   logic [2:0]                             cc_out;
   logic [CNT_WIDTH-1:0]                   retired_cnt;
   logic [CNT_WIDTH-1:0]                   mispredict_cnt;

   modport master (
      output head_valid, head_opcode, head_dest, head_value, head_predict,
             head_tag, rf_tag, dmem_resp,
      input  rf_we, rf_clr_busy, rob_pop, flush, pcmux_sel, new_pc,
             dmem_write, ldstr_pop, cc_out, retired_cnt, mispredict_cnt
   );

   modport slave (
      input  head_valid, head_opcode, head_dest, head_value, head_predict,
             head_tag, rf_tag, dmem_resp,
      output rf_we, rf_clr_busy, rob_pop, flush, pcmux_sel, new_pc,
             dmem_write, ldstr_pop, cc_out, retired_cnt, mispredict_cnt
   );
endinterface

// File: rtl/commit_unit_multi.sv
// In-order multi-lane retirement stage for an lc3b out-of-order core.
// Retires up to COMMIT_WIDTH ROB entries per cycle (lane 0 = ROB head),
// resolves branch mispredicts and traps with a fetch redirect, serialises
// stores through a dmem request/response handshake, and holds the
// architectural condition codes plus retire/mispredict counters.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - commit_unit_multi_if.slave (ROB head lanes in, retire effects out)
module commit_unit_multi #(
   parameter int DATA_WIDTH     = 16,
   parameter int ROB_ADDR_WIDTH = 3,
   parameter int COMMIT_WIDTH   = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   commit_unit_multi_if.slave   bus
);
   localparam int PW = $clog2(COMMIT_WIDTH + 1);

   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LDB  = 4'h2;
   localparam logic [3:0] OP_STB  = 4'h3;
   localparam logic [3:0] OP_JSR  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LDR  = 4'h6;
   localparam logic [3:0] OP_STR  = 4'h7;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_SHF  = 4'hD;
   localparam logic [3:0] OP_LEA  = 4'hE;
   localparam logic [3:0] OP_TRAP = 4'hF;

   typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} state_t;

   state_t                  state, next_state;
   logic [2:0]              cc, cc_next;
   logic                    mis_inc;
   logic                    stop;
   logic                    keep;
   logic [COMMIT_WIDTH-1:0] we_raw;
   logic [COMMIT_WIDTH-1:0] rf_we, rf_clr_busy;
   logic [PW-1:0]           rob_pop;
   logic                    flush, pcmux_sel, dmem_write, ldstr_pop;
   logic [DATA_WIDTH-1:0]   new_pc;
   logic [CNT_WIDTH-1:0]    retired_cnt, mispredict_cnt;

   function automatic logic [2:0] gencc(input logic [DATA_WIDTH-1:0] v);
      if (v[DATA_WIDTH-1])
         return 3'b100;
      else if (v == '0)
         return 3'b010;
      else
         return 3'b001;
   endfunction

   // Outputs are forced quiet while rst is held so a reset during a store
   // drops dmem_write immediately, even with a store still at the head.
   // cc_next doubles as the forwarded CC seen by younger branch lanes.
   always_comb begin
      next_state  = state;
      cc_next     = cc;
      mis_inc     = 1'b0;
      stop        = 1'b0;
      keep        = 1'b0;
      we_raw      = '0;
      rf_we       = '0;
      rf_clr_busy = '0;
      rob_pop     = '0;
      flush       = 1'b0;
      pcmux_sel   = 1'b0;
      new_pc      = '0;
      dmem_write  = 1'b0;
      ldstr_pop   = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               for (int i = 0; i < COMMIT_WIDTH; i++) begin
                  if (!stop) begin
                     if (!bus.head_valid[i]) begin
                        stop = 1'b1;
                     end else if (bus.head_opcode[4*i +: 4] == OP_STR ||
                                  bus.head_opcode[4*i +: 4] == OP_STB) begin
                        // Stores only leave from the head, one at a time.
                        stop = 1'b1;
                        if (i == 0) begin
                           dmem_write = 1'b1;
                           if (bus.dmem_resp) begin
                              rob_pop   = PW'(1);
                              ldstr_pop = 1'b1;
                           end else begin
                              next_state = ST_WAIT;
                           end
                        end
                     end else begin
                        rob_pop = rob_pop + PW'(1);
                        case (bus.head_opcode[4*i +: 4])
                           OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_LDR, OP_LDB: begin
                              we_raw[i] = 1'b1;
                              cc_next   = gencc(bus.head_value[DATA_WIDTH*i +: DATA_WIDTH]);
                           end
                           OP_JSR: begin
                              we_raw[i] = 1'b1;
                           end
                           OP_BR: begin
                              if ((|(bus.head_dest[3*i +: 3] & cc_next)) != bus.head_predict[i]) begin
                                 flush      = 1'b1;
                                 pcmux_sel  = 1'b1;
                                 new_pc     = bus.head_value[DATA_WIDTH*i +: DATA_WIDTH];
                                 mis_inc    = 1'b1;
                                 next_state = FLUSH;
                                 stop       = 1'b1;
                              end
                           end
                           OP_TRAP: begin
                              flush      = 1'b1;
                              pcmux_sel  = 1'b1;
                              new_pc     = bus.head_value[DATA_WIDTH*i +: DATA_WIDTH];
                              next_state = FLUSH;
                              stop       = 1'b1;
                           end
                           default: ;
                        endcase
                     end
                  end
               end
            end
            ST_WAIT: begin
               dmem_write = 1'b1;
               if (bus.dmem_resp) begin
                  rob_pop    = PW'(1);
                  ldstr_pop  = 1'b1;
                  next_state = IDLE;
               end
            end
            FLUSH: begin
               next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end

      // When several retiring lanes write the same register, only the
      // youngest writes it and only it may release the busy bit.
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         keep = we_raw[i];
         for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
            if (we_raw[j] && bus.head_dest[3*j +: 3] == bus.head_dest[3*i +: 3])
               keep = 1'b0;
         end
         rf_we[i]       = keep;
         rf_clr_busy[i] = keep &&
            (bus.rf_tag[ROB_ADDR_WIDTH*i +: ROB_ADDR_WIDTH] ==
             bus.head_tag[ROB_ADDR_WIDTH*i +: ROB_ADDR_WIDTH]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cc             <= 3'b010;
         retired_cnt    <= '0;
         mispredict_cnt <= '0;
      end else begin
         state          <= next_state;
         cc             <= cc_next;
         retired_cnt    <= retired_cnt + CNT_WIDTH'(rob_pop);
         mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(mis_inc);
      end
   end

   assign bus.rf_we          = rf_we;
   assign bus.rf_clr_busy    = rf_clr_busy;
   assign bus.rob_pop        = rob_pop;
   assign bus.flush          = flush;
   assign bus.pcmux_sel      = pcmux_sel;
   assign bus.new_pc         = new_pc;
   assign bus.dmem_write     = dmem_write;
   assign bus.ldstr_pop      = ldstr_pop;
   assign bus.cc_out         = cc;
   assign bus.retired_cnt    = retired_cnt;
   assign bus.mispredict_cnt = mispredict_cnt;
endmodule

// File: tb/tb_commit_unit_multi.sv
// Scoreboard bench for commit_unit_multi (COMMIT_WIDTH=2, DATA_WIDTH=16).
// Directed vectors push hand-computed per-cycle expectations into a queue;
// a negedge monitor pops them and compares every DUT output.
module tb_commit_unit_multi;
   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_STR  = 4'h7;
   localparam logic [3:0] OP_RTI  = 4'h8;
   localparam logic [3:0] OP_TRAP = 4'hF;

   typedef struct {
      string       name;
      logic [1:0]  rf_we;
      logic [1:0]  clr;
      logic [1:0]  pop;
      logic        flush;
      logic        pcsel;
      logic [15:0] new_pc;
      logic        dwrite;
      logic        ldpop;
      logic [2:0]  cc;
      logic [15:0] ret;
      logic [15:0] mis;
   } exp_t;

   logic clk;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t expQ[$];

   logic [1:0]  stg_valid;
   logic [7:0]  stg_op;
   logic [5:0]  stg_dest;
   logic [31:0] stg_val;
   logic [1:0]  stg_pred;
   logic [5:0]  stg_tag;
   logic [5:0]  stg_rft;
   logic        stg_resp;
   logic        stg_rst;

   commit_unit_multi_if #(.DATA_WIDTH(16), .ROB_ADDR_WIDTH(3), .COMMIT_WIDTH(2), .CNT_WIDTH(16)) bus ();

   commit_unit_multi #(.DATA_WIDTH(16), .ROB_ADDR_WIDTH(3), .COMMIT_WIDTH(2), .CNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mkExp(input string name, input logic [1:0] rf_we, input logic [1:0] clr,
                                  input logic [1:0] pop, input logic flush, input logic pcsel,
                                  input logic [15:0] new_pc, input logic dwrite, input logic ldpop,
                                  input logic [2:0] cc, input logic [15:0] ret, input logic [15:0] mis);
      exp_t e;
      e.name = name; e.rf_we = rf_we; e.clr = clr; e.pop = pop; e.flush = flush;
      e.pcsel = pcsel; e.new_pc = new_pc; e.dwrite = dwrite; e.ldpop = ldpop;
      e.cc = cc; e.ret = ret; e.mis = mis;
      return e;
   endfunction

   task automatic clearLanes();
      stg_valid = '0; stg_op = '0; stg_dest = '0; stg_val = '0;
      stg_pred = '0; stg_tag = '0; stg_rft = '0; stg_resp = 1'b0;
   endtask

   task automatic setLane(input int lane, input logic [3:0] op, input logic [2:0] dest,
                          input logic [15:0] val, input logic pred, input logic [2:0] tag,
                          input logic [2:0] rft);
      stg_valid[lane]         = 1'b1;
      stg_op[lane*4 +: 4]     = op;
      stg_dest[lane*3 +: 3]   = dest;
      stg_val[lane*16 +: 16]  = val;
      stg_pred[lane]          = pred;
      stg_tag[lane*3 +: 3]    = tag;
      stg_rft[lane*3 +: 3]    = rft;
   endtask

   task automatic applyStimulus(input exp_t e);
      @(posedge clk);
      #1;
      rst              = stg_rst;
      bus.head_valid   = stg_valid;
      bus.head_opcode  = stg_op;
      bus.head_dest    = stg_dest;
      bus.head_value   = stg_val;
      bus.head_predict = stg_pred;
      bus.head_tag     = stg_tag;
      bus.rf_tag       = stg_rft;
      bus.dmem_resp    = stg_resp;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput(e.name, "rf_we",          32'(bus.rf_we),          32'(e.rf_we));
         checkOutput(e.name, "rf_clr_busy",    32'(bus.rf_clr_busy),    32'(e.clr));
         checkOutput(e.name, "rob_pop",        32'(bus.rob_pop),        32'(e.pop));
         checkOutput(e.name, "flush",          32'(bus.flush),          32'(e.flush));
         checkOutput(e.name, "pcmux_sel",      32'(bus.pcmux_sel),      32'(e.pcsel));
         checkOutput(e.name, "new_pc",         32'(bus.new_pc),         32'(e.new_pc));
         checkOutput(e.name, "dmem_write",     32'(bus.dmem_write),     32'(e.dwrite));
         checkOutput(e.name, "ldstr_pop",      32'(bus.ldstr_pop),      32'(e.ldpop));
         checkOutput(e.name, "cc_out",         32'(bus.cc_out),         32'(e.cc));
         checkOutput(e.name, "retired_cnt",    32'(bus.retired_cnt),    32'(e.ret));
         checkOutput(e.name, "mispredict_cnt", 32'(bus.mispredict_cnt), 32'(e.mis));
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.head_valid = '0; bus.head_opcode = '0; bus.head_dest = '0; bus.head_value = '0;
      bus.head_predict = '0; bus.head_tag = '0; bus.rf_tag = '0; bus.dmem_resp = 1'b0;
      clearLanes();
      stg_rst = 1'b1;
      $display("[TB] starting commit_unit_multi bench");

      // Reset state
      applyStimulus(mkExp("reset0", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b010, 16'd0, 16'd0));
      applyStimulus(mkExp("reset1", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b010, 16'd0, 16'd0));
      stg_rst = 1'b0;

      // Dual ALU retire; youngest value 0xFFFF sets n
      clearLanes();
      setLane(0, OP_ADD, 3'd1, 16'h0005, 0, 3'd0, 3'd0);
      setLane(1, OP_ADD, 3'd2, 16'hFFFF, 0, 3'd1, 3'd1);
      applyStimulus(mkExp("dual_add", 2'b11, 2'b11, 2'd2, 0, 0, 16'h0, 0, 0, 3'b010, 16'd0, 16'd0));

      clearLanes();
      applyStimulus(mkExp("idle_after_add", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b100, 16'd2, 16'd0));

      // Same destination in both lanes: younger wins
      clearLanes();
      setLane(0, OP_ADD, 3'd3, 16'h0001, 0, 3'd2, 3'd3);
      setLane(1, OP_AND, 3'd3, 16'h0000, 0, 3'd3, 3'd3);
      applyStimulus(mkExp("same_dest", 2'b10, 2'b10, 2'd2, 0, 0, 16'h0, 0, 0, 3'b100, 16'd2, 16'd0));

      // Branch mispredict using forwarded z from lane 0
      clearLanes();
      setLane(0, OP_ADD, 3'd1, 16'h0000, 0, 3'd4, 3'd4);
      setLane(1, OP_BR,  3'b010, 16'h1234, 0, 3'd5, 3'd0);
      applyStimulus(mkExp("br_mispredict", 2'b01, 2'b01, 2'd2, 1, 1, 16'h1234, 0, 0, 3'b010, 16'd4, 16'd0));

      // FLUSH cycle ignores a stale valid head
      clearLanes();
      setLane(0, OP_ADD, 3'd4, 16'h0007, 0, 3'd6, 3'd6);
      applyStimulus(mkExp("flush_cycle", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b010, 16'd6, 16'd1));

      // Forwarded n makes brz not taken: prediction correct, no flush
      clearLanes();
      setLane(0, OP_ADD, 3'd5, 16'h8000, 0, 3'd6, 3'd6);
      setLane(1, OP_BR,  3'b010, 16'h2222, 0, 3'd7, 3'd0);
      applyStimulus(mkExp("br_forward_ok", 2'b01, 2'b01, 2'd2, 0, 0, 16'h0, 0, 0, 3'b010, 16'd6, 16'd1));

      // ALU then store in lane 1: store waits for the head
      clearLanes();
      setLane(0, OP_ADD, 3'd6, 16'h0003, 0, 3'd7, 3'd7);
      setLane(1, OP_STR, 3'd0, 16'h0000, 0, 3'd0, 3'd0);
      applyStimulus(mkExp("add_then_str", 2'b01, 2'b01, 2'd1, 0, 0, 16'h0, 0, 0, 3'b100, 16'd8, 16'd1));

      clearLanes();
      setLane(0, OP_STR, 3'd0, 16'h0000, 0, 3'd0, 3'd0);
      applyStimulus(mkExp("str_issue", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 1, 0, 3'b001, 16'd9, 16'd1));

      setLane(1, OP_ADD, 3'd2, 16'h0004, 0, 3'd1, 3'd1);
      applyStimulus(mkExp("str_wait3", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 1, 0, 3'b001, 16'd9, 16'd1));
      applyStimulus(mkExp("str_wait4", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 1, 0, 3'b001, 16'd9, 16'd1));

      stg_resp = 1'b1;
      applyStimulus(mkExp("str_resp", 2'b00, 2'b00, 2'd1, 0, 0, 16'h0, 1, 1, 3'b001, 16'd9, 16'd1));

      clearLanes();
      applyStimulus(mkExp("str_done", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b001, 16'd10, 16'd1));

      // Trap at head stops the run; younger add not written
      clearLanes();
      setLane(0, OP_TRAP, 3'd0, 16'h0040, 0, 3'd1, 3'd0);
      setLane(1, OP_ADD,  3'd1, 16'h0009, 0, 3'd2, 3'd2);
      applyStimulus(mkExp("trap", 2'b00, 2'b00, 2'd1, 1, 1, 16'h0040, 0, 0, 3'b001, 16'd10, 16'd1));
      applyStimulus(mkExp("trap_flush", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b001, 16'd11, 16'd1));

      // Single-cycle store: response in the issue cycle
      clearLanes();
      setLane(0, OP_STR, 3'd0, 16'h0000, 0, 3'd3, 3'd0);
      stg_resp = 1'b1;
      applyStimulus(mkExp("str_single", 2'b00, 2'b00, 2'd1, 0, 0, 16'h0, 1, 1, 3'b001, 16'd11, 16'd1));

      // Invalid head blocks younger valid lane
      clearLanes();
      setLane(1, OP_ADD, 3'd1, 16'h0001, 0, 3'd4, 3'd4);
      applyStimulus(mkExp("head_invalid", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b001, 16'd12, 16'd1));

      // Invalid opcode retires silently; busy tag mismatch keeps busy
      clearLanes();
      setLane(0, OP_RTI, 3'd1, 16'h0055, 0, 3'd1, 3'd1);
      setLane(1, OP_ADD, 3'd2, 16'h0000, 0, 3'd2, 3'd5);
      applyStimulus(mkExp("bad_opcode", 2'b10, 2'b00, 2'd2, 0, 0, 16'h0, 0, 0, 3'b001, 16'd12, 16'd1));

      // Reset during a store wait
      clearLanes();
      setLane(0, OP_STR, 3'd0, 16'h0000, 0, 3'd4, 3'd0);
      applyStimulus(mkExp("str_issue2", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 1, 0, 3'b010, 16'd14, 16'd1));
      applyStimulus(mkExp("str_wait_b", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 1, 0, 3'b010, 16'd14, 16'd1));
      stg_rst = 1'b1;
      applyStimulus(mkExp("rst_mid_store", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b010, 16'd0, 16'd0));
      stg_rst = 1'b0;
      clearLanes();
      applyStimulus(mkExp("after_reset", 2'b00, 2'b00, 2'd0, 0, 0, 16'h0, 0, 0, 3'b010, 16'd0, 16'd0));

      @(posedge clk);
      @(negedge clk);
      #1;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
